// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and the write-arbiter state encoding used by the
// FIFO front-end blocks.
package fifo_pkg;

  localparam int f_WIDTH    = 8;
  localparam int f_DEPTH    = 16;
  localparam int f_AF_LEVEL = 12;
  localparam int f_AE_LEVEL = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake lanes plus FIFO write port, as seen by the write arbiter.
interface fifo_wr_arbiter_if #(
  parameter int f_WIDTH = fifo_pkg::f_WIDTH,
  parameter int N_REQ   = 4
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*f_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]         req_ready;
  logic                     f_full;
  logic                     f_AF;
  logic [f_WIDTH-1:0]       f_in;
  logic                     WR_EN;
  logic [IDX_W-1:0]         grant_id;
  logic                     busy;

  modport master (
    output req_valid, req_data, f_full, f_AF,
    input  req_ready, f_in, WR_EN, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, f_full, f_AF,
    output req_ready, f_in, WR_EN, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_pick.sv
// Round-robin priority pick: first set request scanning last_grant+1, +2, ...
// wrapping modulo N_REQ.
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Scan from the farthest candidate down so the nearest one wins last.
  always_comb begin
    int cand;
    logic [IDX_W-1:0] cand_idx;
    found    = 1'b0;
    index    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand     = (int'(last_grant) + k) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        found = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among N_REQ producers,
// throttled by the FIFO full / almost-full flags.
module fifo_wr_arbiter #(
  parameter int f_WIDTH   = fifo_pkg::f_WIDTH,
  parameter int N_REQ     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               asyn_rst_n,
  fifo_wr_arbiter_if.slave   bus
);

  import fifo_pkg::*;

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  arb_state_e       state;
  logic [IDX_W-1:0] grant_id_q;
  logic [IDX_W-1:0] last_grant;
  logic [CNT_W-1:0] beat_cnt;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             cur_valid;
  logic [f_WIDTH-1:0] lane [N_REQ];

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .index      (pick_idx)
  );

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane[i] = bus.req_data[i*f_WIDTH +: f_WIDTH];
  end

  assign cur_valid    = bus.req_valid[grant_id_q];
  assign bus.f_in     = lane[grant_id_q];
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = (state == BUSY);
  assign bus.WR_EN    = (state == BUSY) && cur_valid && !bus.f_full;

  always_comb begin
    bus.req_ready = '0;
    if (state == BUSY && !bus.f_full) bus.req_ready[grant_id_q] = 1'b1;
  end

  // A dropped valid releases the grant even while the FIFO is full.
  always_ff @(posedge clk or negedge asyn_rst_n) begin
    if (!asyn_rst_n) begin
      state      <= IDLE;
      grant_id_q <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found && !bus.f_AF) begin
            grant_id_q <= pick_idx;
            beat_cnt   <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (!cur_valid) begin
            last_grant <= grant_id_q;
            state      <= IDLE;
          end else if (!bus.f_full) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == CNT_W'(BURST_LEN - 1)) begin
              last_grant <= grant_id_q;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a burst-level
// round-robin reference model.
module tb_fifo_wr_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int BL = 4;

  typedef struct {
    int           gid;
    logic [W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic asyn_rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.f_WIDTH(W), .N_REQ(N)) bus ();

  fifo_wr_arbiter #(
    .f_WIDTH   (W),
    .N_REQ     (N),
    .BURST_LEN (BL)
  ) dut (
    .clk        (clk),
    .asyn_rst_n (asyn_rst_n),
    .bus        (bus.slave)
  );

  wr_t          exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_writes = 0;

  // Reference model: grant ownership, burst beats and the round-robin pointer.
  bit           m_busy;
  int           m_gid, m_last, m_beats;

  bit           exp_busy;
  bit           exp_wr;
  logic [N-1:0] exp_ready;
  int           exp_gid;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_gid     = 0;
    m_last    = N - 1;
    m_beats   = 0;
    exp_busy  = 1'b0;
    exp_wr    = 1'b0;
    exp_ready = '0;
    exp_gid   = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs and predict what the DUT must present before the next edge.
  task automatic apply_stimulus(input logic [N-1:0] v, input logic full, input logic af);
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.f_full    = full;
    bus.f_AF      = af;
    exp_busy  = m_busy;
    exp_gid   = m_gid;
    exp_ready = '0;
    exp_wr    = 1'b0;
    if (m_busy) begin
      if (!full) exp_ready[m_gid] = 1'b1;
      if (!v[m_gid]) begin
        m_busy = 1'b0;
        m_last = m_gid;
      end else if (!full) begin
        exp_wr = 1'b1;
        exp_q.push_back('{gid: m_gid, data: d[m_gid*W +: W]});
        m_beats++;
        if (m_beats == BL) begin
          m_busy = 1'b0;
          m_last = m_gid;
        end
      end
    end else if (v != '0 && !af) begin
      for (int k = 1; k <= N; k++) begin
        if (v[(m_last + k) % N]) begin
          m_gid = (m_last + k) % N;
          break;
        end
      end
      m_busy  = 1'b1;
      m_beats = 0;
    end
  endtask

  task automatic random_cycles(input int cycles, input int p_valid, input int p_full, input int p_af);
    logic [N-1:0] v;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(99) < p_valid);
      apply_stimulus(v, $urandom_range(99) < p_full, $urandom_range(99) < p_af);
    end
  endtask

  task automatic hold_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      bus.req_valid = '1;
      model_reset();
    end
  endtask

  // Monitor: per-cycle control outputs, and a scoreboard pop on every write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #1;
      check_output("busy", bus.busy, exp_busy);
      check_output("req_ready", bus.req_ready, exp_ready);
      check_output("grant_id", bus.grant_id, exp_gid);
      check_output("WR_EN", bus.WR_EN, exp_wr);
      if (bus.WR_EN) begin
        n_writes++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL write_expected: got write of %0h with empty scoreboard at %0t", bus.f_in, $time);
        end else begin
          e = exp_q.pop_front();
          n_checks--;
          check_output("f_in", bus.f_in, e.data);
          check_output("write_grant", bus.grant_id, e.gid);
        end
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.f_full    = 1'b0;
    bus.f_AF      = 1'b0;
    model_reset();

    hold_reset(3);
    @(negedge clk);
    asyn_rst_n = 1'b1;
    apply_stimulus('1, 1'b0, 1'b0);

    // Continuous requests: bursts of BL to 0,1,2,3,0 with one idle cycle between.
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      apply_stimulus('1, 1'b0, 1'b0);
    end

    random_cycles(300, 80, 20, 25);

    // Reach the middle of a burst, then pull reset asynchronously.
    for (int c = 0; c < 50 && !(m_busy && m_beats >= 1); c++) begin
      @(negedge clk);
      apply_stimulus('1, 1'b0, 1'b0);
    end
    check_output("mid_burst_reached", m_busy, 1'b1);
    @(negedge clk);
    apply_stimulus('1, 1'b0, 1'b0);
    #2;
    check_output("queue_drained", exp_q.size(), 0);
    asyn_rst_n = 1'b0;
    #1;
    check_output("rst_WR_EN", bus.WR_EN, 1'b0);
    check_output("rst_req_ready", bus.req_ready, '0);
    check_output("rst_busy", bus.busy, 1'b0);
    check_output("rst_grant_id", bus.grant_id, 0);
    check_output("rst_f_in", bus.f_in, bus.req_data[W-1:0]);
    hold_reset(2);
    @(negedge clk);
    asyn_rst_n = 1'b1;
    apply_stimulus('1, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      apply_stimulus('1, 1'b0, 1'b0);
    end

    random_cycles(200, 60, 50, 40);
    random_cycles(200, 90, 5, 10);

    @(negedge clk);
    apply_stimulus('0, 1'b0, 1'b0);
    @(negedge clk);
    apply_stimulus('0, 1'b0, 1'b0);
    #2;
    check_output("final_queue_empty", exp_q.size(), 0);
    n_checks++;
    if (n_writes < 100) begin
      n_fail++;
      $display("[TB] FAIL write_count: got %0d writes required at least 100", n_writes);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the team's FIFO (f_in / WR_EN, f_full / f_AF flags) among N_REQ producers using per-requester valid/ready handshakes. Grants are issued in bursts of up to BURST_LEN beats and are throttled by the FIFO almost-full and full flags. It sits directly in front of the FIFO write port; the FIFO's read side is untouched.

## Interface
- f_WIDTH, 8, data width (matches FIFO)
- N_REQ, 4, number of requesters (2..8)
- BURST_LEN, 4, max beats per grant (1..15)
- clk  in  1  rising-edge clock
- asyn_rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- req_valid  in  N_REQ  requester i has a word on its data lane
- req_data  in  N_REQ*f_WIDTH  lane i = bits [i*f_WIDTH +: f_WIDTH]
- req_ready  out  N_REQ  one-hot or zero; transfer on lane i when req_valid[i] & req_ready[i]
- f_full  in  1  FIFO full flag
- f_AF  in  1  FIFO almost-full flag
- f_in  out  f_WIDTH  FIFO write data
- WR_EN  out  1  FIFO write enable
- grant_id  out  clog2(N_REQ)  index of current/last grantee
- busy  out  1  high in BUSY state

## Operation
- States: IDLE, BUSY. Registers: state, grant_id, last_grant, beat_cnt.
- IDLE: if any req_valid and f_AF=0 -> pick first valid index scanning last_grant+1, +2, ... (mod N_REQ); load grant_id, beat_cnt=0, go BUSY. Else stay IDLE. f_AF=1 blocks new grants only.
- BUSY: req_ready[grant_id] = ~f_full; all other ready bits 0. WR_EN = req_valid[grant_id] & ~f_full; f_in = lane grant_id (combinational mux).
- Each transfer increments beat_cnt. After the transfer that makes beat_cnt == BURST_LEN -> IDLE, last_grant <= grant_id.
- BUSY with req_valid[grant_id]=0 -> IDLE, last_grant <= grant_id (grant released, no write that cycle).
- f_full=1 in BUSY: stall; no write, beat_cnt held, grant held regardless of f_AF.
- In IDLE: req_ready all 0, WR_EN=0, f_in = lane grant_id (don't-care, but stable).
- beat_cnt width clog2(BURST_LEN+1); never exceeds BURST_LEN.

## Timing
- Reset values: state=IDLE, busy=0, req_ready=0, WR_EN=0, grant_id=0, last_grant=N_REQ-1 (requester 0 wins first), beat_cnt=0; f_in = lane 0.
- Arbitration latency 1 cycle: request seen in IDLE at edge t, first possible write on edge t+1.
- One IDLE bubble between bursts; peak throughput BURST_LEN/(BURST_LEN+1).
- WR_EN and req_ready are combinational from registered state and f_full; no write ever issued while f_full=1.
- Reset asserted mid-burst: all outputs return to reset values immediately (async), partial burst abandoned, no WR_EN glitch after deassertion until a new arbitration cycle.
- Simultaneous valid drop and f_full in BUSY: release takes priority (go IDLE).

## Structure
- Shared package fifo_pkg: f_WIDTH, f_DEPTH, f_AF_LEVEL, f_AE_LEVEL defaults and arbiter state encoding (IDLE=0, BUSY=1).
- One combinational sub-module rr_priority_pick (inputs: req vector, last_grant; outputs: found, index). FSM, counters and muxes stay in fifo_wr_arbiter.

## Test plan
- Reset: asyn_rst_n=0 mid-burst -> WR_EN=0, req_ready=0, busy=0 immediately; after release, req_valid=4'b1111 grants requester 0 first.
- Round-robin: all 4 valid continuously, BURST_LEN=4 -> grant order 0,1,2,3,0; each burst writes exactly 4 words; one idle cycle between bursts.
- Early release: requester 2 sends 0x11,0x22 then drops valid -> 2 writes, IDLE next cycle, next grant goes to 3 (if valid).
- Full stall: f_full=1 during beat 2 of requester 1 for 3 cycles -> WR_EN=0, req_ready=0, beat_cnt held; burst completes with 4 total writes, data order preserved.
- Almost-full: f_AF=1 in IDLE with requests pending -> no grant; f_AF=1 asserting mid-burst -> burst continues to BURST_LEN.
- Data path: requester 3 sends 0xaa,0xbb,0xcc,0xdd -> f_in sequence on WR_EN cycles is exactly 0xaa,0xbb,0xcc,0xdd, grant_id=3.
